// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and types for the MIPS fetch stage
package mips_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int unsigned PC_STEP   = 4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter with redirect mux and +4 adder
module fetch_pc_reg
  import mips_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_pc_write,
  input  logic              i_jump,
  input  logic [ADDR_W-1:0] i_jump_target,
  input  logic              i_branch_taken,
  input  logic [ADDR_W-1:0] i_branch_target,
  input  logic              i_advance,
  output logic [ADDR_W-1:0] o_pc,
  output logic [ADDR_W-1:0] o_pc_plus4
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic [ADDR_W-1:0] w_pc_plus4;

  // Wraps naturally at the top of the address space.
  assign w_pc_plus4 = r_pc + ADDR_W'(PC_STEP);

  always_comb begin
    w_pc_next = r_pc;
    if (i_pc_write && i_jump) begin
      w_pc_next = i_jump_target;
    end else if (i_pc_write && i_branch_taken) begin
      w_pc_next = i_branch_target;
    end else if (i_advance) begin
      w_pc_next = w_pc_plus4;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc <= PC_RESET;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign o_pc       = r_pc;
  assign o_pc_plus4 = w_pc_plus4;

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage with IF/ID pipeline register
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              PCWrite,
  input  logic              IF_ID_Write,
  input  logic              IF_Flush,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] BranchTarget,
  input  logic              jump,
  input  logic [ADDR_W-1:0] JumpTarget,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] PC,
  output logic [DATA_W-1:0] IF_ID_Instruction,
  output logic [ADDR_W-1:0] IF_ID_PCPlus4,
  output logic              IF_ID_Valid
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_next;
  logic              r_drop;
  logic              w_drop_next;
  logic [DATA_W-1:0] r_skid;
  logic [DATA_W-1:0] r_ifid_instr;
  logic [ADDR_W-1:0] r_ifid_pc4;
  logic              r_ifid_valid;

  logic              w_accept;
  logic              w_rsp;
  logic              w_avail;
  logic              w_redirect;
  logic              w_deliver;
  logic              w_park;
  logic [DATA_W-1:0] w_word;
  logic [ADDR_W-1:0] w_pc;
  logic [ADDR_W-1:0] w_pc_plus4;

  assign w_accept   = imem_req && imem_ready;
  assign w_rsp      = (r_state == WAIT) && imem_rvalid;
  assign w_avail    = (w_rsp && !r_drop) || (r_state == HOLD);
  assign w_redirect = PCWrite && (jump || branch_taken);
  assign w_deliver  = w_avail && PCWrite && IF_ID_Write && !w_redirect;
  assign w_word     = (r_state == HOLD) ? r_skid : imem_rdata;
  // A good response that cannot be handed to ID yet is parked in the skid register.
  assign w_park     = w_rsp && !r_drop && !w_deliver && !w_redirect;

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .PC_RESET (PC_RESET)
  ) u_pc (
    .i_clk           (Clk),
    .i_reset         (Reset),
    .i_pc_write      (PCWrite),
    .i_jump          (jump),
    .i_jump_target   (JumpTarget),
    .i_branch_taken  (branch_taken),
    .i_branch_target (BranchTarget),
    .i_advance       (w_deliver),
    .o_pc            (w_pc),
    .o_pc_plus4      (w_pc_plus4)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= FETCH;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_drop  <= w_drop_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      FETCH: if (w_accept) w_state_next = WAIT;
      WAIT: begin
        if (imem_rvalid) begin
          w_state_next = w_park ? HOLD : FETCH;
        end
      end
      HOLD: if (w_deliver || w_redirect) w_state_next = FETCH;
      default: w_state_next = FETCH;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    if ((r_state == FETCH) && !Reset) begin
      imem_req = 1'b1;
    end
  end

  // A redirect leaves the in-flight request on the wrong path; its response must be eaten.
  always_comb begin
    w_drop_next = r_drop;
    if (w_rsp && r_drop) begin
      w_drop_next = 1'b0;
    end else if (w_redirect && (((r_state == WAIT) && !imem_rvalid) || w_accept)) begin
      w_drop_next = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_skid <= NOP_INSTR;
    end else if (w_park) begin
      r_skid <= imem_rdata;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ifid_instr <= NOP_INSTR;
      r_ifid_pc4   <= '0;
      r_ifid_valid <= 1'b0;
    end else if (IF_Flush) begin
      r_ifid_instr <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
    end else if (!IF_ID_Write) begin
      r_ifid_instr <= r_ifid_instr;
    end else if (w_deliver) begin
      r_ifid_instr <= w_word;
      r_ifid_pc4   <= w_pc_plus4;
      r_ifid_valid <= 1'b1;
    end else begin
      r_ifid_instr <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
    end
  end

  assign imem_addr         = w_pc;
  assign PC                = w_pc;
  assign IF_ID_Instruction = r_ifid_instr;
  assign IF_ID_PCPlus4     = r_ifid_pc4;
  assign IF_ID_Valid       = r_ifid_valid;

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - scoreboard bench for the fetch stage
module tb_if_fetch_stage;

  logic        Clk;
  logic        Reset, PCWrite, IF_ID_Write, IF_Flush, branch_taken, jump;
  logic [31:0] BranchTarget, JumpTarget;
  logic        imem_req, imem_ready, imem_rvalid, IF_ID_Valid;
  logic [31:0] imem_addr, imem_rdata, PC, IF_ID_Instruction, IF_ID_PCPlus4;

  if_fetch_stage dut (
    .Clk(Clk), .Reset(Reset), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
    .IF_Flush(IF_Flush), .branch_taken(branch_taken), .BranchTarget(BranchTarget),
    .jump(jump), .JumpTarget(JumpTarget), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .PC(PC), .IF_ID_Instruction(IF_ID_Instruction), .IF_ID_PCPlus4(IF_ID_PCPlus4),
    .IF_ID_Valid(IF_ID_Valid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;
  int n_deliv = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;
  exp_t        exp_q[$];
  logic [31:0] tail_pc;

  logic        req_s, valid_s;
  logic [31:0] addr_s, instr_s;
  bit          pend;
  logic [31:0] paddr;
  int          wait_c;
  int          ready_mode;
  int          lat_mode;
  bit          spur_en;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8) return 32'h8C22_0004;
    return (a * 32'h9E37_79B1) ^ 32'h2400_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  initial begin
    req_s = 1'b0; addr_s = '0; valid_s = 1'b0; instr_s = '0;
    forever begin
      @(negedge Clk);
      req_s = imem_req; addr_s = imem_addr; valid_s = IF_ID_Valid; instr_s = IF_ID_Instruction;
    end
  end

  // Memory with one outstanding request and 1..3 cycle latency.
  task automatic mem_step();
    if (Reset) begin
      pend = 1'b0;
      imem_rvalid = 1'b0;
    end else begin
      if (imem_rvalid) begin
        imem_rvalid = 1'b0;
        pend = 1'b0;
      end
      if (req_s && imem_ready) begin
        pend = 1'b1;
        paddr = addr_s;
        wait_c = (lat_mode < 0) ? int'($urandom_range(0, 2)) : lat_mode;
      end
      if (pend) begin
        if (wait_c == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata = mem_word(paddr);
        end else begin
          wait_c--;
        end
      end else if (spur_en && ($urandom_range(0, 7) == 0)) begin
        imem_rvalid = 1'b1;
        imem_rdata = $urandom;
      end
    end
    if (ready_mode == 1) imem_ready = 1'b1;
    else if (ready_mode == 0) imem_ready = 1'b0;
    else imem_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Reference: the delivered stream is the sequential program from the last redirect target.
  task automatic cyc(input bit rst, input bit pcw, input bit ifw, input bit fl,
                     input bit j, input logic [31:0] jt, input bit b, input logic [31:0] bt);
    exp_t e;
    mem_step();
    Reset = rst; PCWrite = pcw; IF_ID_Write = ifw; IF_Flush = fl;
    jump = j; JumpTarget = jt; branch_taken = b; BranchTarget = bt;
    if (rst) begin
      exp_q.delete();
      tail_pc = 32'h0;
    end else if (pcw && (j || b)) begin
      exp_q.delete();
      tail_pc = j ? jt : bt;
    end
    while (exp_q.size() < 4) begin
      e.instr = mem_word(tail_pc);
      e.pc4 = tail_pc + 32'd4;
      exp_q.push_back(e);
      tail_pc = tail_pc + 32'd4;
    end
    @(posedge Clk);
    #2;
  endtask

  task automatic run_normal();
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (Reset) begin
        chk_b("req_in_reset", imem_req, 1'b0);
      end else begin
        if (IF_ID_Write && !IF_Flush && IF_ID_Valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_delivery actual=%h required=none", IF_ID_Instruction);
          end else begin
            e = exp_q.pop_front();
            chk("deliver_instr", IF_ID_Instruction, e.instr);
            chk("deliver_pcplus4", IF_ID_PCPlus4, e.pc4);
            chk("pc_after_deliver", PC, e.pc4);
            n_deliv++;
          end
        end
        if (IF_Flush) chk_b("flush_bubble", IF_ID_Valid, 1'b0);
        if (!IF_Flush && !IF_ID_Write) begin
          chk_b("ifid_hold_valid", IF_ID_Valid, valid_s);
          chk("ifid_hold_instr", IF_ID_Instruction, instr_s);
        end
        if (req_s && !imem_ready && !(PCWrite && (jump || branch_taken))) begin
          chk_b("req_stable", imem_req, 1'b1);
          chk("addr_stable", imem_addr, addr_s);
        end
      end
    end
  end

  initial begin
    logic [31:0] pc_hold;
    logic [31:0] jt, bt;
    bit          rst, pcw, ifw, fl, j, b;
    int          k;

    Reset = 1'b1; PCWrite = 1'b1; IF_ID_Write = 1'b1; IF_Flush = 1'b0;
    jump = 1'b0; branch_taken = 1'b0; JumpTarget = '0; BranchTarget = '0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    pend = 1'b0; paddr = '0; wait_c = 0; tail_pc = '0;
    ready_mode = 1; lat_mode = 0; spur_en = 1'b0;

    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("reset_pc", PC, 32'h0);
      chk_b("reset_valid", IF_ID_Valid, 1'b0);
      chk("reset_instr", IF_ID_Instruction, 32'h0);
      chk("reset_pcplus4", IF_ID_PCPlus4, 32'h0);
    end

    k = 0;
    while (n_deliv < 2 && k < 20) begin run_normal(); k++; end
    chk("seq_deliveries", 32'(n_deliv), 32'd2);
    chk("seq_pc", PC, 32'h8);

    ready_mode = 0;
    for (int i = 0; i < 4; i++) begin
      run_normal();
      chk_b("stall_req", imem_req, 1'b1);
      chk("stall_addr", imem_addr, 32'h8);
      chk("stall_pc", PC, 32'h8);
      chk_b("stall_valid", IF_ID_Valid, 1'b0);
    end

    ready_mode = 1;
    run_normal();
    chk_b("hold_accepted", imem_req, 1'b0);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("hold_pc", PC, 32'h8);
      chk_b("hold_valid", IF_ID_Valid, 1'b0);
    end
    run_normal();
    chk("hold_release_pc", PC, 32'hC);
    chk("hold_release_instr", IF_ID_Instruction, 32'h8C22_0004);
    chk_b("hold_release_valid", IF_ID_Valid, 1'b1);
    run_normal();
    chk_b("hold_once", IF_ID_Valid, 1'b0);

    lat_mode = 2;
    k = 0;
    while (!(PC == 32'h10 && !imem_req) && k < 20) begin run_normal(); k++; end
    chk_b("reach_wait_0x10", (PC == 32'h10) && !imem_req, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
    chk_b("jump_flush_valid", IF_ID_Valid, 1'b0);
    chk("jump_pc", PC, 32'h40);
    k = 0;
    while (!imem_req && k < 10) begin run_normal(); k++; end
    chk_b("jump_refetch_req", imem_req, 1'b1);
    chk("jump_refetch_addr", imem_addr, 32'h40);
    lat_mode = 0;

    pc_hold = PC;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100);
    chk("branch_stall_pc", PC, pc_hold);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h100);
    chk("branch_pc", PC, 32'h100);

    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    k = 0;
    while (PC != 32'h0 && k < 20) begin run_normal(); k++; end
    chk("wrap_pc", PC, 32'h0);
    chk("wrap_pcplus4", IF_ID_PCPlus4, 32'h0);
    chk_b("wrap_valid", IF_ID_Valid, 1'b1);

    k = 0;
    while (imem_req && k < 10) begin run_normal(); k++; end
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("midreset_pc", PC, 32'h0);
    chk_b("midreset_valid", IF_ID_Valid, 1'b0);

    lat_mode = -1; ready_mode = 2; spur_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      pcw = ($urandom_range(0, 4) != 0);
      ifw = pcw;
      if ($urandom_range(0, 9) == 0) ifw = !ifw;
      j = ($urandom_range(0, 15) == 0);
      b = ($urandom_range(0, 11) == 0);
      jt = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : (32'($urandom_range(0, 63)) << 2);
      bt = 32'h100 + (32'($urandom_range(0, 63)) << 2);
      fl = pcw && (j || b) && ($urandom_range(0, 1) == 1);
      cyc(rst, pcw, ifw, fl, j, jt, b, bt);
    end
    chk_b("liveness", n_deliv >= 300, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
